uart_tx_fifo_ctrl: RTL

- Drain controller for the 8-bit UART TX fifo.
- Sequences fifo reads, captures the registered fifo output and presents each byte to the TX serializer over a valid/ready handshake.
- Tracks fifo occupancy by monitoring both fifo ports, raises a low-watermark interrupt, counts transmitted bytes and supports a software flush.
- Sits between the AXI-Lite write path (which owns fifo_wr_en) and the UART transmitter.

---
 rtl/uart_pkg.sv | 10 +
 rtl/fifo_level_tracker.sv | 36 +++
 rtl/uart_tx_fifo_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, default sizes and width helper for the UART TX fifo drain path
package uart_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DATA_DEPTH = 128;
  localparam int DEF_CNT_WIDTH = 16;
  typedef enum logic [2:0] {IDLE, READ, LOAD, PRESENT, FLUSH} tx_ctrl_state_t;
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_level_tracker.sv
// fifo_level_tracker: fifo occupancy from observed write/read strobes plus registered low-watermark flag
module fifo_level_tracker import uart_pkg::*; #(
  parameter int DATA_DEPTH = DEF_DATA_DEPTH,
  localparam int LW = level_width(DATA_DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          full,
  input  logic          empty,
  input  logic [LW-1:0] threshold,
  output logic [LW-1:0] level,
  output logic          thr_irq
);
  logic [LW-1:0] level_q, level_d;
  logic thr_irq_q, thr_irq_d, inc, dec;
  always_comb begin
    inc = wr_en & ~full;
    dec = rd_en & ~empty;
    level_d = (inc & ~dec & (level_q != LW'(DATA_DEPTH))) ? level_q + 1'b1 :
              (dec & ~inc & (level_q != '0)) ? level_q - 1'b1 : level_q;
    thr_irq_d = level_d <= threshold;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      level_q <= '0;
      thr_irq_q <= 1'b1;
    end else begin
      level_q <= level_d;
      thr_irq_q <= thr_irq_d;
    end
  end
  assign level = level_q;
  assign thr_irq = thr_irq_q;
endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: drains the TX fifo into the serializer handshake, tracks level, counts bytes, flushes
module uart_tx_fifo_ctrl import uart_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  localparam int LW = level_width(DATA_DEPTH)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  enable,
  input  logic                  flush_req,
  input  logic [LW-1:0]         threshold,
  input  logic                  fifo_empty,
  input  logic                  fifo_full,
  input  logic                  fifo_wr_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [LW-1:0]         level,
  output logic                  thr_irq,
  output logic                  busy,
  output logic                  flush_done,
  output logic [CNT_WIDTH-1:0]  tx_count
);
  tx_ctrl_state_t state_q, state_d;
  logic rd_en_q, rd_en_d, tx_valid_q, tx_valid_d, flush_pend_q, flush_pend_d, flush_done_q, flush_done_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [CNT_WIDTH-1:0] tx_count_q, tx_count_d;
  always_comb begin
    state_d = state_q;
    rd_en_d = 1'b0;
    tx_valid_d = tx_valid_q;
    tx_data_d = tx_data_q;
    tx_count_d = tx_count_q;
    flush_done_d = 1'b0;
    flush_pend_d = flush_pend_q | flush_req;
    case (state_q)
      IDLE: begin
        if (flush_pend_q) state_d = FLUSH;
        else if (enable & ~fifo_empty) begin
          state_d = READ;
          rd_en_d = 1'b1;
        end
      end
      READ: state_d = LOAD;
      LOAD: begin
        tx_data_d = fifo_data_out;
        state_d = flush_pend_d ? FLUSH : PRESENT;
        tx_valid_d = ~flush_pend_d;
      end
      PRESENT: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          tx_count_d = tx_count_q + 1'b1;
          state_d = flush_pend_d ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        // a request landing on the completing cycle survives and starts another flush
        if (fifo_empty) begin
          state_d = IDLE;
          flush_done_d = 1'b1;
          flush_pend_d = flush_req;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q <= '0;
      tx_count_q <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q <= tx_data_d;
      tx_count_q <= tx_count_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
    end
  end
  // flushing reads every cycle the fifo holds data, so new writes are drained too
  assign fifo_rd_en = rd_en_q | ((state_q == FLUSH) & ~fifo_empty);
  assign tx_data = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy = state_q != IDLE;
  assign flush_done = flush_done_q;
  assign tx_count = tx_count_q;
  fifo_level_tracker #(.DATA_DEPTH(DATA_DEPTH)) u_level (
    .Clk(Clk),
    .Reset(Reset),
    .wr_en(fifo_wr_en),
    .rd_en(fifo_rd_en),
    .full(fifo_full),
    .empty(fifo_empty),
    .threshold(threshold),
    .level(level),
    .thr_irq(thr_irq)
  );
endmodule
